// File: rtl/adf4351_int_ctrl_pkg.sv
// Shared types and constants for the ADF4351 integer-N controller:
// state encodings, register control bits, step table and R0 field layout.
package adf4351_pkg;

    typedef enum logic [2:0] {
        ST_RST,
        ST_INIT_LOAD,
        ST_LOAD,
        ST_SHIFT_LO,
        ST_SHIFT_HI,
        ST_LE_HI,
        ST_LE_GAP,
        ST_IDLE
    } state_t;

    // Sequencer view; the transfer itself is tracked by the serialiser.
    typedef enum logic [2:0] {
        C_RST,
        C_INIT_LOAD,
        C_LOAD,
        C_XFER,
        C_IDLE
    } ctrl_t;

    localparam logic [2:0] CTRL_R0 = 3'd0;
    localparam logic [2:0] CTRL_R1 = 3'd1;
    localparam logic [2:0] CTRL_R2 = 3'd2;
    localparam logic [2:0] CTRL_R3 = 3'd3;
    localparam logic [2:0] CTRL_R4 = 3'd4;
    localparam logic [2:0] CTRL_R5 = 3'd5;

    localparam int R0_INT_MSB  = 30;
    localparam int R0_INT_LSB  = 15;
    localparam int R0_FRAC_MSB = 14;
    localparam int R0_FRAC_LSB = 3;

    function automatic logic [16:0] step_size(input logic [1:0] idx);
        case (idx)
            2'd1:    return 17'd10;
            2'd2:    return 17'd100;
            default: return 17'd1;
        endcase
    endfunction

    function automatic logic [31:0] make_r0(input logic [15:0] int_v,
                                            input logic [11:0] frac_v);
        logic [31:0] w;
        w = '0;
        w[R0_INT_MSB:R0_INT_LSB]   = int_v;
        w[R0_FRAC_MSB:R0_FRAC_LSB] = frac_v;
        w[2:0]                     = CTRL_R0;
        return w;
    endfunction

endpackage

// File: rtl/adf4351_int_ctrl_if.sv
// Bundle of key inputs, ADF4351 pins and status outputs of the controller.
interface adf4351_int_ctrl_if;
    import adf4351_pkg::*;

    // Handshake: k_up/k_dn/k_step are single-cycle strobes with no ready; they
    // are always accepted. busy is status only: high while a word is in flight.
    logic        k_up;
    logic        k_dn;
    logic        k_step;
    logic        sclk;
    logic        sdata;
    logic        le;
    logic        busy;
    logic [15:0] int_val;
    logic [1:0]  step_idx;
    state_t      dbg_state;

    modport master (
        output k_up, k_dn, k_step,
        input  sclk, sdata, le, busy, int_val, step_idx, dbg_state
    );

    modport slave (
        input  k_up, k_dn, k_step,
        output sclk, sdata, le, busy, int_val, step_idx, dbg_state
    );

endinterface

// File: rtl/adf4351_spi_tx.sv
// 3-wire serialiser: shifts one 32-bit word MSB first (device samples on the
// rising sclk), then pulses LE and holds a gap before signalling done.
module adf4351_spi_tx
    import adf4351_pkg::*;
#(
    parameter int CLK_DIV = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [31:0] word,
    output logic        done,
    output logic        sclk,
    output logic        sdata,
    output logic        le,
    output state_t      tx_state
);

    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

    logic [DW-1:0] div_cnt;
    logic [5:0]    bit_cnt;
    logic [30:0]   sreg;

    wire div_end = (div_cnt == DIV_LAST);

    assign done = (tx_state == ST_LE_GAP) && div_end;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_state <= ST_IDLE;
            div_cnt  <= '0;
            bit_cnt  <= '0;
            sreg     <= '0;
            sclk     <= 1'b0;
            sdata    <= 1'b0;
            le       <= 1'b0;
        end else begin
            case (tx_state)
                ST_IDLE: begin
                    if (start) begin
                        sreg     <= word[30:0];
                        sdata    <= word[31];
                        sclk     <= 1'b0;
                        le       <= 1'b0;
                        bit_cnt  <= 6'd32;
                        div_cnt  <= '0;
                        tx_state <= ST_SHIFT_LO;
                    end
                end
                ST_SHIFT_LO: begin
                    if (div_end) begin
                        div_cnt  <= '0;
                        sclk     <= 1'b1;
                        bit_cnt  <= bit_cnt - 6'd1;
                        tx_state <= ST_SHIFT_HI;
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end
                ST_SHIFT_HI: begin
                    if (div_end) begin
                        div_cnt <= '0;
                        sclk    <= 1'b0;
                        if (bit_cnt == 6'd0) begin
                            le       <= 1'b1;
                            sdata    <= 1'b0;
                            tx_state <= ST_LE_HI;
                        end else begin
                            // Next bit changes together with the falling edge.
                            sdata    <= sreg[30];
                            sreg     <= {sreg[29:0], 1'b0};
                            tx_state <= ST_SHIFT_LO;
                        end
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end
                ST_LE_HI: begin
                    if (div_end) begin
                        div_cnt  <= '0;
                        le       <= 1'b0;
                        tx_state <= ST_LE_GAP;
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end
                ST_LE_GAP: begin
                    if (div_end) begin
                        div_cnt  <= '0;
                        tx_state <= ST_IDLE;
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end
                default: begin
                    tx_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: rtl/adf4351_int_ctrl.sv
// ADF4351 integer-N controller: writes R5..R0 after reset, then tracks key
// strobes on INT and rewrites R0 whenever the setting has changed.
module adf4351_int_ctrl
    import adf4351_pkg::*;
#(
    parameter int          CLK_DIV  = 4,
    parameter int unsigned INT_INIT = 100,
    parameter int unsigned INT_MIN  = 75,
    parameter int unsigned INT_MAX  = 65535,
    parameter logic [11:0] FRAC_VAL = 12'd0,
    parameter logic [31:0] R1_VAL   = 32'h0800_8011,
    parameter logic [31:0] R2_VAL   = 32'h0000_4E42,
    parameter logic [31:0] R3_VAL   = 32'h0000_04B3,
    parameter logic [31:0] R4_VAL   = 32'h00EC_803C,
    parameter logic [31:0] R5_VAL   = 32'h0058_0005
) (
    input  logic            clk,
    input  logic            rst_n,
    adf4351_int_ctrl_if.slave bus
);

    ctrl_t       ctrl;
    logic [2:0]  word_idx;
    logic        busy_q;
    logic [15:0] int_val_q;
    logic [1:0]  step_idx_q;
    logic        dirty;

    logic        tx_start;
    logic [31:0] tx_word;
    logic        tx_done;
    logic        sclk_w;
    logic        sdata_w;
    logic        le_w;
    state_t      tx_state;

    logic [16:0] step;
    logic [16:0] sum17;
    logic [16:0] dif17;
    logic [15:0] int_next;
    logic        key_chg;
    logic        r0_load;

    always_comb begin
        step     = step_size(step_idx_q);
        sum17    = {1'b0, int_val_q} + step;
        dif17    = {1'b0, int_val_q} - step;
        int_next = int_val_q;
        if (bus.k_up && !bus.k_dn) begin
            int_next = (sum17 > 17'(INT_MAX)) ? 16'(INT_MAX) : sum17[15:0];
        end else if (bus.k_dn && !bus.k_up) begin
            // Bit 16 set means the subtraction borrowed below zero.
            int_next = (dif17[16] || dif17 < 17'(INT_MIN)) ? 16'(INT_MIN) : dif17[15:0];
        end
        key_chg = (int_next != int_val_q);
    end

    always_comb begin
        tx_start = (ctrl == C_INIT_LOAD) || (ctrl == C_LOAD);
        r0_load  = tx_start && (word_idx == 3'd0);
        case (word_idx)
            3'd5:    tx_word = R5_VAL;
            3'd4:    tx_word = R4_VAL;
            3'd3:    tx_word = R3_VAL;
            3'd2:    tx_word = R2_VAL;
            3'd1:    tx_word = R1_VAL;
            default: tx_word = make_r0(int_val_q, FRAC_VAL);
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl       <= C_RST;
            word_idx   <= 3'd5;
            busy_q     <= 1'b0;
            int_val_q  <= 16'(INT_INIT);
            step_idx_q <= 2'd0;
            dirty      <= 1'b0;
        end else begin
            int_val_q <= int_next;
            if (bus.k_step) begin
                step_idx_q <= (step_idx_q == 2'd2) ? 2'd0 : step_idx_q + 2'd1;
            end
            // A key arriving in the R0 load cycle wins over the clear.
            dirty <= key_chg | (dirty & ~r0_load);

            case (ctrl)
                C_RST: begin
                    word_idx <= 3'd5;
                    busy_q   <= 1'b1;
                    ctrl     <= C_INIT_LOAD;
                end
                C_INIT_LOAD, C_LOAD: begin
                    ctrl <= C_XFER;
                end
                C_XFER: begin
                    if (tx_done) begin
                        if (word_idx != 3'd0) begin
                            word_idx <= word_idx - 3'd1;
                            ctrl     <= C_INIT_LOAD;
                        end else begin
                            busy_q <= 1'b0;
                            ctrl   <= C_IDLE;
                        end
                    end
                end
                C_IDLE: begin
                    if (dirty) begin
                        word_idx <= 3'd0;
                        busy_q   <= 1'b1;
                        ctrl     <= C_LOAD;
                    end
                end
                default: begin
                    ctrl <= C_RST;
                end
            endcase
        end
    end

    adf4351_spi_tx #(
        .CLK_DIV (CLK_DIV)
    ) u_spi_tx (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (tx_start),
        .word     (tx_word),
        .done     (tx_done),
        .sclk     (sclk_w),
        .sdata    (sdata_w),
        .le       (le_w),
        .tx_state (tx_state)
    );

    always_comb begin
        case (ctrl)
            C_RST:       bus.dbg_state = ST_RST;
            C_INIT_LOAD: bus.dbg_state = ST_INIT_LOAD;
            C_LOAD:      bus.dbg_state = ST_LOAD;
            C_XFER:      bus.dbg_state = tx_state;
            default:     bus.dbg_state = ST_IDLE;
        endcase
    end

    assign bus.sclk     = sclk_w;
    assign bus.sdata    = sdata_w;
    assign bus.le       = le_w;
    assign bus.busy     = busy_q;
    assign bus.int_val  = int_val_q;
    assign bus.step_idx = step_idx_q;

endmodule

// File: tb/tb_adf4351_int_ctrl.sv
// Directed bench for adf4351_int_ctrl: expected register words are queued as
// stimulus is issued and a pin-level monitor decodes and compares each word.
`timescale 1ns/1ps
module tb_adf4351_int_ctrl;

    localparam logic [31:0] R1 = 32'h0800_8011;
    localparam logic [31:0] R2 = 32'h0000_4E42;
    localparam logic [31:0] R3 = 32'h0000_04B3;
    localparam logic [31:0] R4 = 32'h00EC_803C;
    localparam logic [31:0] R5 = 32'h0058_0005;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    adf4351_int_ctrl_if bus();

    adf4351_int_ctrl dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail = 0;
    logic [31:0] exp_q[$];

    int          words_seen = 0;
    int          mon_bits = 0;
    logic [31:0] mon_sh = '0;
    logic        sclk_q = 1'b0;
    logic        le_q = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Monitor: rebuild each word from sclk rises, compare on the LE rise.
    always @(negedge clk) begin
        if (!rst_n) begin
            mon_bits = 0;
            mon_sh   = '0;
            sclk_q   = 1'b0;
            le_q     = 1'b0;
        end else begin
            if (bus.sclk && !sclk_q) begin
                mon_sh = {mon_sh[30:0], bus.sdata};
                mon_bits++;
            end
            if (bus.le && !le_q) begin
                words_seen++;
                check("word_bits", 32'(mon_bits), 32'd32);
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_word: got %0h, expected no word", mon_sh);
                end else begin
                    check("reg_word", mon_sh, exp_q.pop_front());
                end
                mon_bits = 0;
            end
            sclk_q = bus.sclk;
            le_q   = bus.le;
        end
    end

    task automatic key(input logic up, input logic dn, input logic st);
        @(negedge clk);
        bus.k_up   = up;
        bus.k_dn   = dn;
        bus.k_step = st;
        @(negedge clk);
        bus.k_up   = 1'b0;
        bus.k_dn   = 1'b0;
        bus.k_step = 1'b0;
    endtask

    task automatic wait_words(input int n, input string name);
        int t;
        t = 0;
        while (!(words_seen >= n && bus.busy == 1'b0) && t < 4000) begin
            @(negedge clk);
            #1;
            t++;
        end
        check(name, 32'(words_seen), 32'(n));
        check({name, "_busy"}, 32'(bus.busy), 32'd0);
    endtask

    task automatic push_init(input logic [15:0] int_v);
        exp_q.push_back(R5);
        exp_q.push_back(R4);
        exp_q.push_back(R3);
        exp_q.push_back(R2);
        exp_q.push_back(R1);
        exp_q.push_back({1'b0, int_v, 15'd0});
    endtask

    task automatic count_busy(input string name);
        int t;
        int cnt;
        t = 0;
        cnt = 0;
        while (bus.busy !== 1'b1 && t < 20) begin
            @(negedge clk);
            t++;
        end
        while (bus.busy === 1'b1 && cnt < 3000) begin
            cnt++;
            @(negedge clk);
        end
        check(name, 32'(cnt), 32'd1590);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int lat;
        bus.k_up   = 1'b0;
        bus.k_dn   = 1'b0;
        bus.k_step = 1'b0;

        // Reset values
        repeat (3) @(negedge clk);
        check("rst_sclk", 32'(bus.sclk), 32'd0);
        check("rst_sdata", 32'(bus.sdata), 32'd0);
        check("rst_le", 32'(bus.le), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_int", 32'(bus.int_val), 32'd100);
        check("rst_step", 32'(bus.step_idx), 32'd0);

        // Full init sequence R5..R0
        push_init(16'd100);
        rst_n = 1'b1;
        count_busy("init_busy_cycles");
        wait_words(6, "init_words");

        // Single k_up at step 1 with key-to-sclk latency
        exp_q.push_back(32'h0032_8000);
        @(negedge clk);
        bus.k_up = 1'b1;
        lat = 0;
        while (lat < 50) begin
            @(posedge clk);
            #1;
            lat++;
            bus.k_up = 1'b0;
            if (bus.sclk === 1'b1) break;
        end
        check("up_sclk_latency", 32'(lat), 32'd7);
        wait_words(7, "up_words");
        check("up_int", 32'(bus.int_val), 32'd101);

        // Step 100, k_dn saturates at INT_MIN, then a no-op k_dn
        key(0, 0, 1);
        key(0, 0, 1);
        check("step_idx_2", 32'(bus.step_idx), 32'd2);
        exp_q.push_back(32'h0025_8000);
        key(0, 1, 0);
        wait_words(8, "dn_sat_words");
        check("dn_sat_int", 32'(bus.int_val), 32'd75);
        key(0, 1, 0);
        repeat (30) @(negedge clk);
        check("dn_noop_int", 32'(bus.int_val), 32'd75);
        check("dn_noop_words", 32'(words_seen), 32'd8);
        check("dn_noop_busy", 32'(bus.busy), 32'd0);

        // Three k_up during an R0 transfer coalesce into one follow-up word
        key(0, 0, 1);
        check("step_wrap", 32'(bus.step_idx), 32'd0);
        exp_q.push_back(32'h0026_0000);
        key(1, 0, 0);
        repeat (20) @(negedge clk);
        check("busy_mid", 32'(bus.busy), 32'd1);
        exp_q.push_back(32'h0027_8000);
        key(1, 0, 0);
        key(1, 0, 0);
        key(1, 0, 0);
        wait_words(10, "coalesce_words");
        check("coalesce_int", 32'(bus.int_val), 32'd79);
        repeat (30) @(negedge clk);
        check("coalesce_no_extra", 32'(words_seen), 32'd10);

        // k_up with k_dn together: no change, no transfer
        key(1, 1, 0);
        repeat (30) @(negedge clk);
        check("updn_int", 32'(bus.int_val), 32'd79);
        check("updn_words", 32'(words_seen), 32'd10);

        // k_step with k_up: old step applies, step advances
        exp_q.push_back(32'h0028_0000);
        key(1, 0, 1);
        check("stepup_int", 32'(bus.int_val), 32'd80);
        check("stepup_idx", 32'(bus.step_idx), 32'd1);
        wait_words(11, "stepup_words");

        // Reset mid-word (bit 12 of R3 during init)
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst2_int", 32'(bus.int_val), 32'd100);
        base = words_seen;
        exp_q.push_back(R5);
        exp_q.push_back(R4);
        rst_n = 1'b1;
        lat = 0;
        while (!(words_seen == base + 2 && mon_bits >= 12) && lat < 2000) begin
            @(negedge clk);
            #1;
            lat++;
        end
        check("abort_point_words", 32'(words_seen), 32'(base + 2));
        check("abort_point_bits", 32'(mon_bits), 32'd12);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_sclk", 32'(bus.sclk), 32'd0);
        check("async_sdata", 32'(bus.sdata), 32'd0);
        check("async_le", 32'(bus.le), 32'd0);
        check("async_busy", 32'(bus.busy), 32'd0);
        repeat (3) @(negedge clk);
        check("abort_no_le", 32'(words_seen), 32'(base + 2));
        check("abort_queue_drained", 32'(exp_q.size()), 32'd0);

        // Init restarts from R5
        push_init(16'd100);
        rst_n = 1'b1;
        count_busy("reinit_busy_cycles");
        wait_words(base + 8, "reinit_words");

        check("final_queue_empty", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
